// File: rtl/matrix3x3_window_gen.sv
// 3x3 neighbourhood window generator: one border-handled window per input pixel, SOF/EOL/EOF marked.
// Windows registered 1 cycle after trigger; in_ready low 1 cycle per line end and IMG_W cycles of end-of-frame flush.
module matrix3x3_window_gen #(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int BORDER_MODE = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic [DATA_W-1:0] p11,
    output logic [DATA_W-1:0] p12,
    output logic [DATA_W-1:0] p13,
    output logic [DATA_W-1:0] p21,
    output logic [DATA_W-1:0] p22,
    output logic [DATA_W-1:0] p23,
    output logic [DATA_W-1:0] p31,
    output logic [DATA_W-1:0] p32,
    output logic [DATA_W-1:0] p33
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam bit            REPL     = (BORDER_MODE != 0);

    typedef struct packed {
        logic [DATA_W-1:0] top;
        logic [DATA_W-1:0] mid;
        logic [DATA_W-1:0] bot;
    } col_t;

    typedef struct packed {
        col_t l;
        col_t m;
        col_t r;
    } win_t;

    typedef enum logic [2:0] {IDLE, ROW0, RUN, EOL, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          last_q, last_d;
    logic          rdy_q, rdy_d;
    col_t          sh0_q, sh0_d, sh1_q, sh1_d;
    win_t          win_q, win_d;
    logic          vld_q, vld_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic          eof_q, eof_d;

    // lb_a holds the most recent complete line, lb_b the one before it
    logic [DATA_W-1:0] lb_a_q [IMG_W];
    logic [DATA_W-1:0] lb_b_q [IMG_W];

    logic          xfer;
    logic          take_sof;
    logic          lb_we;
    logic [CW-1:0] wr_col;
    logic [CW-1:0] f_prev;
    logic [CW-1:0] f_next;
    col_t          new_col;
    col_t          left_col;
    col_t          edge_col;
    col_t          fl_l, fl_m, fl_r;

    always_comb begin
        xfer     = in_valid & rdy_q;
        take_sof = xfer & in_sof;
        lb_we    = xfer & (in_sof | (state_q != IDLE));
        wr_col   = in_sof ? '0 : col_q;

        // Column entering the window on a transfer; top border applies while centre row is 0
        new_col.top = (row_q == ROW_ONE) ? (REPL ? lb_a_q[col_q] : '0) : lb_b_q[col_q];
        new_col.mid = lb_a_q[col_q];
        new_col.bot = in_data;
        left_col    = (col_q == COL_ONE) ? (REPL ? sh0_q : '0) : sh1_q;
        edge_col    = REPL ? sh0_q : '0;

        // Flush reads three neighbouring columns of the last two lines, bottom row is border
        f_prev   = (col_q == '0) ? '0 : col_q - COL_ONE;
        f_next   = (col_q == COL_LAST) ? COL_LAST : col_q + COL_ONE;
        fl_l.top = lb_b_q[f_prev];
        fl_l.mid = lb_a_q[f_prev];
        fl_l.bot = REPL ? lb_a_q[f_prev] : '0;
        fl_m.top = lb_b_q[col_q];
        fl_m.mid = lb_a_q[col_q];
        fl_m.bot = REPL ? lb_a_q[col_q] : '0;
        fl_r.top = lb_b_q[f_next];
        fl_r.mid = lb_a_q[f_next];
        fl_r.bot = REPL ? lb_a_q[f_next] : '0;
        if (!REPL && col_q == '0) begin
            fl_l = '0;
        end
        if (!REPL && col_q == COL_LAST) begin
            fl_r = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        last_d  = last_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        win_d   = win_q;
        vld_d   = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        eof_d   = 1'b0;

        case (state_q)
            IDLE, ROW0, RUN: begin
                if (take_sof) begin
                    // Any in_sof restarts: pixel becomes (0,0), pending windows are dropped
                    state_d = ROW0;
                    col_d   = COL_ONE;
                    row_d   = '0;
                    last_d  = 1'b0;
                end else if (xfer && state_q == ROW0) begin
                    if (col_q == COL_LAST) begin
                        state_d = RUN;
                        col_d   = '0;
                        row_d   = ROW_ONE;
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end else if (xfer && state_q == RUN) begin
                    sh1_d = sh0_q;
                    sh0_d = new_col;
                    if (col_q != '0) begin
                        vld_d   = 1'b1;
                        win_d.l = left_col;
                        win_d.m = sh0_q;
                        win_d.r = new_col;
                        sof_d   = (col_q == COL_ONE) && (row_q == ROW_ONE);
                    end
                    if (col_q == COL_LAST) begin
                        state_d = EOL;
                        col_d   = '0;
                        last_d  = (row_q == ROW_LAST);
                        row_d   = (row_q == ROW_LAST) ? row_q : row_q + ROW_ONE;
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end
            end
            EOL: begin
                vld_d   = 1'b1;
                eol_d   = 1'b1;
                win_d.l = sh1_q;
                win_d.m = sh0_q;
                win_d.r = edge_col;
                state_d = last_q ? FLUSH : RUN;
            end
            FLUSH: begin
                vld_d   = 1'b1;
                win_d.l = fl_l;
                win_d.m = fl_m;
                win_d.r = fl_r;
                if (col_q == COL_LAST) begin
                    eol_d   = 1'b1;
                    eof_d   = 1'b1;
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                    last_d  = 1'b0;
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rdy_d = (state_d == IDLE) || (state_d == ROW0) || (state_d == RUN);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b1;
            sh0_q   <= '0;
            sh1_q   <= '0;
            win_q   <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            last_q  <= last_d;
            rdy_q   <= rdy_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            win_q   <= win_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (lb_we) begin
            lb_a_q[wr_col] <= in_data;
            lb_b_q[wr_col] <= lb_a_q[wr_col];
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_sof   = sof_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;
    assign p11       = win_q.l.top;
    assign p12       = win_q.m.top;
    assign p13       = win_q.r.top;
    assign p21       = win_q.l.mid;
    assign p22       = win_q.m.mid;
    assign p23       = win_q.r.mid;
    assign p31       = win_q.l.bot;
    assign p32       = win_q.m.bot;
    assign p33       = win_q.r.bot;

endmodule

// File: tb/tb_matrix3x3_window_gen.sv
// Directed bench: 4x3 frame of 10*row+col pixels driven into a replicate-border and a zero-border
// instance side by side; continuous, gapped, pre-sof/resync and mid-frame reset scenarios.
module tb_matrix3x3_window_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;

    localparam logic [71:0] FIRST_REP  = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd10, 8'd10, 8'd11};
    localparam logic [71:0] LAST_REP   = {8'd12, 8'd13, 8'd13, 8'd22, 8'd23, 8'd23, 8'd22, 8'd23, 8'd23};
    localparam logic [71:0] FIRST_ZERO = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd10, 8'd11};
    localparam logic [71:0] LAST_ZERO  = {8'd12, 8'd13, 8'd0, 8'd22, 8'd23, 8'd0, 8'd0, 8'd0, 8'd0};

    typedef struct packed {
        logic [71:0] w;
        logic        sof;
        logic        eol;
        logic        eof;
    } rec_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          rdy1, vld1, sof1, eol1, eof1;
    logic          rdy0, vld0, sof0, eol0, eof0;
    logic [DW-1:0] w1 [9];
    logic [DW-1:0] w0 [9];
    logic [71:0]   win1, win0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_xfer_cyc = 0;
    int   first_vld_cyc = -1;
    int   gap_viol = 0;
    int   low_run = 0;
    int   low_runs[$];
    logic seen_xfer = 1'b0;
    logic seen_stall = 1'b0;
    rec_t q1[$];
    rec_t q0[$];

    always #5 sys_clk = ~sys_clk;

    assign win1 = {w1[0], w1[1], w1[2], w1[3], w1[4], w1[5], w1[6], w1[7], w1[8]};
    assign win0 = {w0[0], w0[1], w0[2], w0[3], w0[4], w0[5], w0[6], w0[7], w0[8]};

    matrix3x3_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) u_dut_rep (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_sof(in_sof), .in_data(in_data), .out_valid(vld1), .out_sof(sof1),
        .out_eol(eol1), .out_eof(eof1),
        .p11(w1[0]), .p12(w1[1]), .p13(w1[2]), .p21(w1[3]), .p22(w1[4]),
        .p23(w1[5]), .p31(w1[6]), .p32(w1[7]), .p33(w1[8])
    );

    matrix3x3_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) u_dut_zero (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_sof(in_sof), .in_data(in_data), .out_valid(vld0), .out_sof(sof0),
        .out_eol(eol0), .out_eof(eof0),
        .p11(w0[0]), .p12(w0[1]), .p13(w0[2]), .p21(w0[3]), .p22(w0[4]),
        .p23(w0[5]), .p31(w0[6]), .p32(w0[7]), .p33(w0[8])
    );

    // What the DUT saw at this edge: a transfer, or a stall cycle (EOL/FLUSH)
    always @(posedge sys_clk) begin
        cyc++;
        seen_xfer  = in_valid & rdy1;
        seen_stall = !rdy1;
    end

    always @(negedge sys_clk) begin
        if (vld1) begin
            q1.push_back({win1, sof1, eol1, eof1});
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            if (!seen_xfer && !seen_stall) gap_viol++;
        end
        if (vld0) q0.push_back({win0, sof0, eol0, eof0});
        if (!rdy1) begin
            low_run++;
        end else if (low_run != 0) begin
            low_runs.push_back(low_run);
            low_run = 0;
        end
    end

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] ref_win(input int cx, input int cy, input bit repl);
        logic [71:0] v = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int   r = cy + dr;
                int   c = cx + dc;
                bit   outside = (r < 0) || (r >= H) || (c < 0) || (c >= W);
                logic [7:0] px;
                if (r < 0) r = 0;
                if (r >= H) r = H - 1;
                if (c < 0) c = 0;
                if (c >= W) c = W - 1;
                px = (outside && !repl) ? 8'd0 : 8'(10 * r + c);
                v = {v[63:0], px};
            end
        end
        return v;
    endfunction

    function automatic rec_t get_rec(input bit repl, input int i);
        if (repl) return (i < q1.size()) ? q1[i] : '0;
        return (i < q0.size()) ? q0[i] : '0;
    endfunction

    task automatic check_frame(input string tag, input bit repl, input int base);
        for (int i = 0; i < W * H; i++) begin
            rec_t r = get_rec(repl, base + i);
            check_val($sformatf("%s_win%0d", tag, i), r.w, ref_win(i % W, i / W, repl));
            check_val($sformatf("%s_mark%0d", tag, i), 72'({r.sof, r.eol, r.eof}),
                      72'({i == 0, (i % W) == W - 1, i == W * H - 1}));
        end
    endtask

    task automatic send(input logic s, input int d);
        int guard = 0;
        in_valid = 1'b1;
        in_sof   = s;
        in_data  = DW'(d);
        while (!rdy1 && guard < 50) begin
            @(negedge sys_clk);
            guard++;
        end
        if (guard >= 50) check_val("rdy_timeout", 72'(rdy1), 72'(1));
        last_xfer_cyc = cyc;
        @(negedge sys_clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(1) == 1) repeat ($urandom_range(2, 1)) @(negedge sys_clk);
                send(r == 0 && c == 0, 10 * r + c);
            end
        end
    endtask

    task automatic wait_windows(input int n);
        int guard = 0;
        while ((q1.size() < n || q0.size() < n) && guard < 200) begin
            @(negedge sys_clk);
            guard++;
        end
        repeat (6) @(negedge sys_clk);
    endtask

    task automatic clear_mon();
        q1.delete();
        q0.delete();
        low_runs.delete();
        first_vld_cyc = -1;
        gap_viol = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ctl"}, 72'({vld1, sof1, eol1, eof1, rdy1, vld0, sof0, eol0, eof0, rdy0}),
                  72'(10'b0000100001));
        check_val({tag, "_win_rep"}, win1, 72'(0));
        check_val({tag, "_win_zero"}, win0, 72'(0));
    endtask

    initial begin
        int          t11;
        logic [71:0] runs;

        // Reset state
        repeat (2) @(negedge sys_clk);
        check_idle_outputs("rst");
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_val("rdy_after_rst", 72'(rdy1 & rdy0), 72'(1));

        // Continuous frame: values, markers, in_ready pattern, latency
        clear_mon();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(r == 0 && c == 0, 10 * r + c);
                if (r == 1 && c == 1) t11 = last_xfer_cyc;
            end
        end
        wait_windows(W * H);
        check_val("s1_cnt_rep", 72'(q1.size()), 72'(12));
        check_val("s1_cnt_zero", 72'(q0.size()), 72'(12));
        check_val("s1_first_rep", get_rec(1, 0).w, FIRST_REP);
        check_val("s1_last_rep", get_rec(1, 11).w, LAST_REP);
        check_val("s1_first_zero", get_rec(0, 0).w, FIRST_ZERO);
        check_val("s1_last_zero", get_rec(0, 11).w, LAST_ZERO);
        check_val("s1_hold_rep", win1, LAST_REP);
        check_val("s1_hold_zero", win0, LAST_ZERO);
        check_frame("s1_rep", 1'b1, 0);
        check_frame("s1_zero", 1'b0, 0);
        check_val("s1_latency", 72'(first_vld_cyc - t11), 72'(1));
        runs = 72'(low_runs.size());
        for (int i = 0; i < low_runs.size() && i < 6; i++) runs = (runs << 8) | 72'(low_runs[i]);
        check_val("s1_rdy_low_runs", runs, 72'h02_01_05);

        // Random valid gaps
        clear_mon();
        send_frame(1'b1);
        wait_windows(W * H);
        check_val("s4_cnt_rep", 72'(q1.size()), 72'(12));
        check_val("s4_cnt_zero", 72'(q0.size()), 72'(12));
        check_frame("s4_rep", 1'b1, 0);
        check_frame("s4_zero", 1'b0, 0);
        check_val("s4_gap_windows", 72'(gap_viol), 72'(0));

        // Pre-sof pixels ignored; resync at (2,1)
        clear_mon();
        send(1'b0, 99);
        send(1'b0, 98);
        send(1'b0, 97);
        repeat (4) @(negedge sys_clk);
        check_val("s5_presof_cnt", 72'(q1.size() + q0.size()), 72'(0));
        for (int i = 0; i < W + 2; i++) send(i == 0, (i < W) ? i : 10 + (i - W));
        send(1'b1, 0);
        for (int i = 1; i < W * H; i++) send(1'b0, 10 * (i / W) + (i % W));
        wait_windows(W * H + 1);
        check_val("s5_cnt_rep", 72'(q1.size()), 72'(13));
        check_val("s5_cnt_zero", 72'(q0.size()), 72'(13));
        check_frame("s5_rep", 1'b1, 1);
        check_frame("s5_zero", 1'b0, 1);

        // Reset in the middle of a frame
        for (int i = 0; i < W + 3; i++) send(i == 0, (i < W) ? i : 10 + (i - W));
        sys_rst = 1'b1;
        #1;
        check_idle_outputs("s6_in_rst");
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_idle_outputs("s6_after_rst");
        clear_mon();
        send_frame(1'b0);
        wait_windows(W * H);
        check_val("s6_cnt_rep", 72'(q1.size()), 72'(12));
        check_val("s6_cnt_zero", 72'(q0.size()), 72'(12));
        check_frame("s6_rep", 1'b1, 0);
        check_frame("s6_zero", 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
